// File: rtl/round_robin_encoder.sv
// Round-robin 4-to-2 request encoder. It holds each grant until ack or timeout,
// and can issue back-to-back grants on ack.
module round_robin_encoder #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic nreset,
    input  logic in0,
    input  logic in1,
    input  logic in2,
    input  logic in3,
    input  logic ack,
    output logic address0,
    output logic address1,
    output logic valid,
    output logic timeout
);

    typedef enum logic {IDLE, GRANT} mode_t;

    // cnt reaching TIMEOUT-1 on a non-ack edge means the grant has been valid TIMEOUT cycles
    localparam int unsigned TO_M1   = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [3:0]  TO_LAST = TO_M1[3:0];
    localparam logic        TO_EN   = (TIMEOUT != 0);

    mode_t       r_mode, w_mode_nxt;
    logic [1:0]  r_ptr, w_ptr_nxt;
    logic [1:0]  r_addr, w_addr_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic        r_valid, w_valid_nxt;
    logic        r_timeout, w_timeout_nxt;
    logic [3:0]  w_req;
    logic [1:0]  w_ptr_inc;

    assign w_req     = {in3, in2, in1, in0};
    assign w_ptr_inc = r_addr + 2'd1;

    // First asserted line scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4)
    function automatic logic [1:0] pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        pick = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) pick = idx;
        end
    endfunction

    always_comb begin
        w_mode_nxt    = r_mode;
        w_ptr_nxt     = r_ptr;
        w_addr_nxt    = r_addr;
        w_cnt_nxt     = r_cnt;
        w_valid_nxt   = r_valid;
        w_timeout_nxt = 1'b0;
        case (r_mode)
            IDLE: begin
                w_valid_nxt = 1'b0;
                if (|w_req) begin
                    w_addr_nxt  = pick(w_req, r_ptr);
                    w_valid_nxt = 1'b1;
                    w_cnt_nxt   = 4'd0;
                    w_mode_nxt  = GRANT;
                end
            end
            GRANT: begin
                if (ack) begin
                    w_ptr_nxt = w_ptr_inc;
                    if (|w_req) begin
                        w_addr_nxt = pick(w_req, w_ptr_inc);
                        w_cnt_nxt  = 4'd0;
                    end else begin
                        w_valid_nxt = 1'b0;
                        w_mode_nxt  = IDLE;
                    end
                end else if (TO_EN && r_cnt == TO_LAST) begin
                    w_valid_nxt   = 1'b0;
                    w_timeout_nxt = 1'b1;
                    w_ptr_nxt     = w_ptr_inc;
                    w_mode_nxt    = IDLE;
                end else if (r_cnt != 4'hF) begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            default: w_mode_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_mode    <= IDLE;
            r_ptr     <= 2'd0;
            r_addr    <= 2'd0;
            r_cnt     <= 4'd0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_mode    <= w_mode_nxt;
            r_ptr     <= w_ptr_nxt;
            r_addr    <= w_addr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_valid   <= w_valid_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign address0 = r_addr[0];
    assign address1 = r_addr[1];
    assign valid    = r_valid;
    assign timeout  = r_timeout;

endmodule

// File: tb/tb_round_robin_encoder.sv
// Scoreboarded bench for round_robin_encoder: a cycle-level reference model pushes
// expected {valid,timeout,address} per edge; a negedge monitor pops and compares.
module tb_round_robin_encoder;

    localparam int TO = 3;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    logic in0 = 0, in1 = 0, in2 = 0, in3 = 0, ack = 0;
    logic address0, address1, valid, timeout;

    int n_checks = 0;
    int n_pass = 0;

    round_robin_encoder #(.TIMEOUT(TO)) dut (
        .clk(clk), .nreset(nreset),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3), .ack(ack),
        .address0(address0), .address1(address1), .valid(valid), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Reference model: a grant is "owned" by index m_addr for m_age cycles so far
    bit m_busy = 0;
    int m_ptr = 0, m_addr = 0, m_age = 0;
    bit m_to = 0;
    logic [3:0] exp_q[$];

    function automatic int first_req(input logic [3:0] r, input int start);
        for (int k = 0; k < 4; k++)
            if (r[(start + k) % 4]) return (start + k) % 4;
        return -1;
    endfunction

    task automatic model_edge();
        logic [3:0] r;
        int w;
        r = {in3, in2, in1, in0};
        if (!nreset) begin
            m_busy = 0; m_ptr = 0; m_addr = 0; m_age = 0; m_to = 0;
            return;
        end
        m_to = 0;
        if (!m_busy) begin
            w = first_req(r, m_ptr);
            if (w >= 0) begin m_addr = w; m_busy = 1; m_age = 1; end
        end else if (ack) begin
            m_ptr = (m_addr + 1) % 4;
            w = first_req(r, m_ptr);
            if (w >= 0) begin m_addr = w; m_age = 1; end
            else m_busy = 0;
        end else if (TO != 0 && m_age == TO) begin
            m_busy = 0; m_to = 1; m_ptr = (m_addr + 1) % 4;
        end else begin
            m_age++;
        end
    endtask

    function automatic logic [3:0] model_out();
        logic [1:0] a;
        a = 2'(m_addr);
        return {m_busy, m_to, a};
    endfunction

    // Drive inputs (called just after a negedge), run one edge, push expectation
    task automatic cyc(input logic [3:0] r, input logic a);
        {in3, in2, in1, in0} = r;
        ack = a;
        @(posedge clk);
        model_edge();
        exp_q.push_back(model_out());
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        logic [3:0] got, exp;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            got = {valid, timeout, address1, address0};
            n_checks++;
            if (got === exp) n_pass++;
            else $display("FAIL outputs t=%0t {valid,timeout,addr} got=%b expected=%b", $time, got, exp);
        end
    end

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%b expected=%b", name, got, exp);
    endtask

    initial begin
        @(negedge clk);
        cyc(4'b0000, 0);
        cyc(4'b0100, 0);                     // request under reset: ignored
        nreset = 1'b1;
        cyc(4'b0000, 0);

        // Fairness: all requesting, ack every cycle from the first grant
        cyc(4'b1111, 0);
        for (int i = 0; i < 5; i++) cyc(4'b1111, 1);
        cyc(4'b0000, 1);

        // Priority rotation: grant 2, ack, then in0+in3 -> 3 then 0
        cyc(4'b0100, 0);
        cyc(4'b0000, 1);
        cyc(4'b1001, 0);
        cyc(4'b1001, 1);
        cyc(4'b0000, 1);

        // Hold/freeze: grant 1, swap request to in0, no ack for a while, then ack
        cyc(4'b0010, 0);
        for (int i = 0; i < 2; i++) cyc(4'b0001, 0);
        cyc(4'b0001, 1);
        cyc(4'b0000, 1);

        // Timeout: in0 held, never ack
        for (int i = 0; i < 7; i++) cyc(4'b0001, 0);
        cyc(4'b0000, 1);
        cyc(4'b0000, 0);

        // Ack/timeout collision: ack on third edge of the grant
        cyc(4'b0010, 0);
        cyc(4'b0000, 0);
        cyc(4'b0000, 0);
        cyc(4'b0000, 1);
        cyc(4'b0000, 0);
        cyc(4'b0000, 0);

        // Asynchronous reset mid-grant on index 2
        cyc(4'b0100, 0);
        cyc(4'b0100, 0);
        #1 nreset = 1'b0;
        #1 check("async_reset", {valid, timeout, address1, address0}, 4'b0000);
        model_edge();
        cyc(4'b0100, 0);
        nreset = 1'b1;
        cyc(4'b0010, 0);                     // ptr back at 0: grant 01
        cyc(4'b0000, 1);

        // Random traffic
        for (int i = 0; i < 600; i++)
            cyc(4'($urandom_range(0, 15)) & (($urandom_range(0, 3) == 0) ? 4'h0 : 4'hF),
                ($urandom_range(0, 3) == 0));
        // Random async reset pulses interleaved with traffic
        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < 20; i++)
                cyc(4'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0));
            #1 nreset = 1'b0;
            #1 check("async_reset_rand", {valid, timeout, address1, address0}, 4'b0000);
            model_edge();
            nreset = 1'b1;
        end

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain got=%0d expected=0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/round_robin_encoder.md
# round_robin_encoder

Sequential 4-to-2 request encoder: the inverse of the team's 2-to-4 decoder. It collects four request lines and presents one winner as a 2-bit address (`address1`,`address0`) with `valid`. It holds that grant until the consumer acknowledges it or a timeout expires. Fairness is round-robin. The encoded address can feed the decoder directly to regenerate a one-hot select.

## Interface
- `TIMEOUT`, default 15: maximum cycles a grant stays valid without `ack`.
  - Legal range 0..15.
  - 0 disables the timeout.
- `clk`  input  1  the single clock; all state changes on the rising edge.
- `nreset`  input  1  asynchronous, active-low reset.
- `in0`..`in3`  input  1 each  request lines, sampled on the rising edge of `clk`.
- `ack`  input  1  consumer has taken the current grant; sampled on the rising edge.
- `address0`  output  1  LSB of the granted request index.
- `address1`  output  1  MSB of the granted request index.
- `valid`  output  1  `address1`/`address0` hold a live grant.
- `timeout`  output  1  one-cycle pulse when a grant is dropped unacknowledged.

## Operation
- All outputs are registered. There is no combinational path from any input to any output.
- State: `mode` (IDLE/GRANT), `ptr[1:0]` (highest-priority index), `cnt[3:0]` (cycles in GRANT).
- Selection: scan the requests in order `ptr`, `ptr+1`, `ptr+2`, `ptr+3`, all mod 4. The first asserted line wins.
- IDLE:
  - `valid`=0.
  - At an edge with any request high: latch the winner index into `address1`/`address0`, set `valid`=1, `cnt`=0, go to GRANT.
  - With no request: stay in IDLE; the address holds its last value.
- GRANT:
  - The address and `valid` are frozen. Request changes, including the granted line dropping, are ignored.
  - `ack`=1 at an edge:
    - `ptr` = granted+1 mod 4.
    - If any request is high at that same edge, select a new winner using the new `ptr`. Stay in GRANT with `valid`=1 and `cnt`=0. This gives a back-to-back grant.
    - Otherwise `valid`=0 and go to IDLE.
  - `ack`=0 with `TIMEOUT`≠0 and `cnt`=`TIMEOUT`-1:
    - Set `valid`=0 and `timeout`=1.
    - Set `ptr` = granted+1 mod 4.
    - Go to IDLE. No same-edge regrant.
  - `ack`=0 otherwise: `cnt` increments and saturates at 15.
- `ack` while `valid`=0 is ignored and has no effect on `ptr`.
- `timeout` is high for exactly one cycle and is otherwise 0.

## Timing
- Reset (`nreset`=0, asynchronous, any time including mid-grant):
  - `valid`=0, `timeout`=0, `address1`=0, `address0`=0.
  - `ptr`=0, `cnt`=0, `mode`=IDLE.
- Reset release: the first edge with `nreset`=1 operates normally.
- Request-to-grant latency: 1 edge. A request high at edge N gives `valid`=1 after edge N.
- Grant lifetime:
  - With `ack` high at the k-th edge after the grant, `valid` stays high for exactly k cycles.
  - Without `ack`, it stays high for exactly `TIMEOUT` cycles; `timeout` pulses in the cycle after the last valid cycle.
- `ack` and timeout on the same edge: `ack` wins, with no `timeout` pulse.
- After a timeout, `valid` is low for at least one cycle.
- Back-to-back grants via `ack` have zero idle cycles.
- Wrap-around: `ptr` after granting index 3 is 0.
- All-four-requesting steady state with `ack` every cycle gives addresses 0,1,2,3,0,…

## Test plan
- Reset check:
  - Stimulus: assert `nreset`=0 during a live grant on index 2.
  - Required: outputs go immediately to `valid`=0, address=00, `timeout`=0. After release, `in1`=1 grants 01 (`ptr` back at 0).
- Fairness:
  - Stimulus: `in0`..`in3` all held 1, `ack`=1 every cycle from the first grant.
  - Required: address sequence 00,01,10,11,00 with `valid` continuously 1.
- Priority rotation:
  - Stimulus: grant on `in2`, `ack`. Then `in0`=1 and `in3`=1 together.
  - Required: next grant 11, then 00.
- Hold/freeze:
  - Stimulus: grant on `in1`; drop `in1` and raise `in0`; `ack`=0 for 5 cycles, then `ack`.
  - Required: address stays 01 for 6 cycles. Next grant 00.
- Timeout (`TIMEOUT`=3):
  - Stimulus: grant on `in0`, never `ack`, `in0` held.
  - Required: `valid` high for 3 cycles, then `timeout`=1 for 1 cycle with `valid`=0. Regrant 00 one cycle later (only requester).
- Ack/timeout collision (`TIMEOUT`=3):
  - Stimulus: `ack` at the third edge of the grant.
  - Required: no `timeout` pulse; normal release.
